// File: rtl/pulse_spacer.sv
// pulse_spacer
//   Source-side pacer placed in front of a toggle-based pulse CDC. Single-cycle
//   events on clk_i (including back-to-back bursts) are counted as pending and
//   re-emitted one at a time on pulse_o. Every pulse is followed by at least
//   GAP low cycles, so a slower destination cannot merge or lose toggles.
//
//   Optional build macro: PULSE_SPACER_ACK_EN
//     Adds ack_i and a WAIT_ACK state. Each pulse after the first is held off
//     until the far end toggles ack_i for the previous pulse.
//
//   Parameters
//     CNT_W  width of the pending counter (backlog up to 2^CNT_W-1)
//     GAP    minimum low cycles on pulse_o after each pulse (1..255)
//     GAP_W  gap counter width, derived from GAP
//
//   Ports
//     clk_i       clock
//     arst_n_i    asynchronous reset, active low
//     event_i     event input, one event per high cycle
//     clr_ovf_i   one-cycle clear of overflow_o
//     ack_i       toggle acknowledge, already in clk_i domain (macro only)
//     pulse_o     registered one-cycle paced pulse
//     pending_o   current backlog count
//     busy_o      state not idle or backlog non-zero
//     overflow_o  sticky: an event was dropped because the backlog was full
module pulse_spacer #(
   parameter int unsigned CNT_W = 4,
   parameter int unsigned GAP   = 3,
   parameter int unsigned GAP_W = $clog2(GAP + 1)
) (
   input  logic             clk_i,
   input  logic             arst_n_i,
   input  logic             event_i,
   input  logic             clr_ovf_i,
`ifdef PULSE_SPACER_ACK_EN
   input  logic             ack_i,
`endif
   output logic             pulse_o,
   output logic [CNT_W-1:0] pending_o,
   output logic             busy_o,
   output logic             overflow_o
);

`ifdef PULSE_SPACER_ACK_EN
   typedef enum logic [1:0] {ST_IDLE, ST_GAP, ST_WAIT_ACK} state_t;
`else
   typedef enum logic {ST_IDLE, ST_GAP} state_t;
`endif

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [GAP_W-1:0] GAP_LD  = GAP_W'(GAP);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [GAP_W-1:0] gcnt;
   logic             issue;
   logic             accept;
   logic             drop;

   // A full counter can still accept when an issue frees a slot this cycle.
   assign issue  = (state == ST_IDLE) && (cnt != '0);
   assign accept = event_i && !((cnt == CNT_MAX) && !issue);
   assign drop   = event_i && !accept;

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         cnt <= '0;
      end else if (accept && !issue) begin
         cnt <= cnt + CNT_W'(1);
      end else if (!accept && issue) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   // Set wins over clear so a drop is never lost to a simultaneous clear.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         overflow_o <= 1'b0;
      end else if (drop) begin
         overflow_o <= 1'b1;
      end else if (clr_ovf_i) begin
         overflow_o <= 1'b0;
      end
   end

`ifdef PULSE_SPACER_ACK_EN
   logic ack_q;
   logic ack_edge;
   logic ack_seen;

   assign ack_edge = ack_i ^ ack_q;

   // An ack toggle that lands during GAP is remembered so WAIT_ACK can exit
   // after a single cycle. Toggles while idle belong to nothing and are ignored.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         ack_q    <= 1'b0;
         ack_seen <= 1'b0;
      end else begin
         ack_q <= ack_i;
         if (issue) begin
            ack_seen <= 1'b0;
         end else if (ack_edge && (state != ST_IDLE)) begin
            ack_seen <= 1'b1;
         end
      end
   end
`endif

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state   <= ST_IDLE;
         gcnt    <= '0;
         pulse_o <= 1'b0;
      end else begin
         pulse_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (issue) begin
                  pulse_o <= 1'b1;
                  state   <= ST_GAP;
                  gcnt    <= GAP_LD;
               end
            end
            ST_GAP: begin
               gcnt <= gcnt - GAP_W'(1);
               if (gcnt == GAP_W'(1)) begin
`ifdef PULSE_SPACER_ACK_EN
                  state <= ST_WAIT_ACK;
`else
                  state <= ST_IDLE;
`endif
               end
            end
`ifdef PULSE_SPACER_ACK_EN
            ST_WAIT_ACK: begin
               if (ack_seen || ack_edge) begin
                  state <= ST_IDLE;
               end
            end
`endif
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign pending_o = cnt;
   assign busy_o    = (state != ST_IDLE) || (cnt != '0);

endmodule
